intr_sched: RTL and testbench

Interrupt scheduler for the DAQ-to-WiFi interrupt line. It collects rising edges from several DAQ event sources (frame done, FIFO threshold, error) and keeps a saturating pending count per source. It grants pending events round-robin and drives a single interrupt output. Each interrupt pulse has a programmable assertion delay, pulse width and post-pulse holdoff, so the WiFi module never sees overlapping or too-closely-spaced interrupts.

---
 rtl/intr_sched.sv | 194 +++++++++++++++++++
 tb/tb_intr_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_sched.sv
// intr_sched: collects rising edges from N_SRC DAQ event sources into saturating
// per-source pending counters, grants them round-robin and emits one interrupt
// pulse per grant with a latched assertion delay, pulse width and holdoff.
module intr_sched #(
  parameter int N_SRC = 3,
  parameter int DLY_W = 8,
  parameter int PW_W  = 8,
  parameter int CNT_W = 4,
  localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [PW_W-1:0]  cfg_width,
  input  logic [DLY_W-1:0] cfg_holdoff,
  input  logic             clr_ovf,
  output logic             intr_out,
  output logic [ID_W-1:0]  intr_id,
  output logic             busy,
  output logic [N_SRC-1:0] ovf
);

  // One shared down-counter serves delay, width and holdoff phases.
  localparam int TMR_W = (DLY_W > PW_W) ? DLY_W : PW_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_ASSERT,
    S_HOLDOFF
  } state_t;

  state_t             r_state;
  logic [N_SRC-1:0]   r_src_d;
  logic [CNT_W-1:0]   r_cnt [N_SRC];
  logic [N_SRC-1:0]   r_ovf;
  logic [ID_W-1:0]    r_last;
  logic [ID_W-1:0]    r_id;
  logic [TMR_W-1:0]   r_tmr;
  logic [PW_W-1:0]    r_width;
  logic [DLY_W-1:0]   r_hold;
  logic               r_intr;

  logic [N_SRC-1:0]   w_evt;
  logic [N_SRC-1:0]   w_dec;
  logic [N_SRC-1:0]   w_ovf_set;
  logic               w_any;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W-1:0]    w_rr_idx;
  logic               w_grant;
  logic [PW_W-1:0]    w_width_eff;

  assign w_evt       = src & ~r_src_d;
  assign w_grant     = (r_state == S_IDLE) && w_any;
  assign w_width_eff = (cfg_width == '0) ? PW_W'(1) : cfg_width;

  assign intr_out = r_intr;
  assign intr_id  = r_id;
  assign busy     = (r_state != S_IDLE);
  assign ovf      = r_ovf;

  // Previous-cycle copy of the source levels for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_d <= '0;
    end else begin
      r_src_d <= src;
    end
  end

  // Round-robin search starting one past the last granted source.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_rr_idx  = '0;
    for (int unsigned off = 1; off <= N_SRC; off++) begin
      w_rr_idx = ID_W'((32'(r_last) + off) % N_SRC);
      if (!w_any && (r_cnt[w_rr_idx] != '0)) begin
        w_any     = 1'b1;
        w_gnt_idx = w_rr_idx;
      end
    end
  end

  // Per-source decrement request and saturation detect.
  always_comb begin
    w_dec = '0;
    if (w_grant) begin
      w_dec[w_gnt_idx] = 1'b1;
    end
    w_ovf_set = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_ovf_set[i] = w_evt[i] & ~w_dec[i] & (r_cnt[i] == '1);
    end
  end

  // Saturating pending counters; a same-cycle event and grant cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (w_evt[i] && !w_dec[i]) begin
          if (r_cnt[i] != '1) begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else if (!w_evt[i] && w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Sticky overflow flags; a new overflow outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~{N_SRC{clr_ovf}}) | w_ovf_set;
    end
  end

  // Pulse sequencer: grant, delay, assert, holdoff, with configuration latched at grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= ID_W'(N_SRC - 1);
      r_id    <= '0;
      r_tmr   <= '0;
      r_width <= '0;
      r_hold  <= '0;
      r_intr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_id    <= w_gnt_idx;
            r_last  <= w_gnt_idx;
            r_width <= w_width_eff;
            r_hold  <= cfg_holdoff;
            if (cfg_delay != '0) begin
              r_tmr   <= TMR_W'(cfg_delay);
              r_state <= S_DELAY;
            end else begin
              // Zero delay: the pulse starts on the grant edge itself.
              r_tmr   <= TMR_W'(w_width_eff);
              r_intr  <= 1'b1;
              r_state <= S_ASSERT;
            end
          end
        end
        S_DELAY: begin
          if (r_tmr == TMR_W'(1)) begin
            r_tmr   <= TMR_W'(r_width);
            r_intr  <= 1'b1;
            r_state <= S_ASSERT;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_ASSERT: begin
          if (r_tmr == TMR_W'(1)) begin
            r_intr <= 1'b0;
            if (r_hold != '0) begin
              r_tmr   <= TMR_W'(r_hold);
              r_state <= S_HOLDOFF;
            end else begin
              r_tmr   <= '0;
              r_state <= S_IDLE;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_HOLDOFF: begin
          if (r_tmr == TMR_W'(1)) begin
            r_tmr   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_intr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_sched.sv
// Scoreboard bench for intr_sched: a transaction-level model predicts each
// pulse (source, start edge, width) plus busy and overflow; a monitor compares.
module tb_intr_sched;
  localparam int N    = 3;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [N-1:0] src;
  logic [7:0] cfg_delay, cfg_width, cfg_holdoff;
  logic       clr_ovf;
  logic       intr_out;
  logic [1:0] intr_id;
  logic       busy;
  logic [N-1:0] ovf;

  intr_sched #(.N_SRC(N), .DLY_W(8), .PW_W(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .src(src), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
    .cfg_holdoff(cfg_holdoff), .clr_ovf(clr_ovf), .intr_out(intr_out),
    .intr_id(intr_id), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int id; int start; int width;} pulse_t;
  pulse_t     expq[$];
  int         pend[N];
  int         ptr;
  int         cyc = 0;
  int         free_at = 0;
  logic [N-1:0] prev_src;
  logic [N-1:0] ovf_m;

  function automatic int pend_sum();
    int s = 0;
    for (int i = 0; i < N; i++) s += pend[i];
    return s;
  endfunction

  always @(posedge clk) begin
    int j, d, w, h;
    bit found;
    logic [N-1:0] set;
    cyc++;
    if (rst) begin
      for (int i = 0; i < N; i++) pend[i] = 0;
      ptr = N - 1;
      free_at = 0;
      prev_src = '0;
      ovf_m = '0;
      expq.delete();
    end else begin
      found = 0;
      j = 0;
      if (cyc >= free_at) begin
        for (int off = 1; off <= N; off++) begin
          if (!found && pend[(ptr + off) % N] > 0) begin
            found = 1;
            j = (ptr + off) % N;
          end
        end
      end
      if (found) begin
        pend[j]--;
        ptr = j;
        d = int'(cfg_delay);
        w = (cfg_width == 0) ? 1 : int'(cfg_width);
        h = int'(cfg_holdoff);
        expq.push_back('{j, cyc + d, w});
        free_at = cyc + d + w + h + 1;
      end
      set = '0;
      for (int i = 0; i < N; i++) begin
        if (src[i] && !prev_src[i]) begin
          if (pend[i] == MAXC) set[i] = 1'b1;
          else pend[i]++;
        end
      end
      ovf_m = (clr_ovf ? '0 : ovf_m) | set;
      prev_src = src;
    end
  end

  // ---------------- monitor ----------------
  bit     in_pulse = 0;
  int     p_start = 0;
  int     exp_w = 0;
  int     n_rise = 0;

  always @(negedge clk) begin
    pulse_t e;
    if (rst) begin
      in_pulse = 0;
      chk("rst_intr_out", intr_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
    end else begin
      chk("busy", busy, (cyc < free_at - 1) ? 1 : 0);
      chk("ovf", ovf, ovf_m);
      if (intr_out && !in_pulse) begin
        in_pulse = 1;
        p_start = cyc;
        n_rise++;
        if (expq.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
          exp_w = -1;
        end else begin
          e = expq.pop_front();
          chk("pulse_id", intr_id, e.id);
          chk("pulse_start", p_start, e.start);
          exp_w = e.width;
        end
      end else if (!intr_out && in_pulse) begin
        in_pulse = 0;
        if (exp_w >= 0) chk("pulse_width", cyc - p_start, exp_w);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_src(input int i);
    src[i] = 1'b1;
    tick(1);
    src[i] = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (k < lim && !(busy == 1'b0 && pend_sum() == 0 && expq.size() == 0 && !in_pulse)) begin
      tick(1);
      k++;
    end
    if (k >= lim) chk("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    int rises_before, k;
    rst = 1'b1;
    src = 3'b001;
    cfg_delay = 8'd5; cfg_width = 8'd4; cfg_holdoff = 8'd2;
    clr_ovf = 1'b0;
    #1;
    chk("init_intr_out", intr_out, 0);
    chk("init_busy", busy, 0);
    chk("init_intr_id", intr_id, 0);
    chk("init_ovf", ovf, 0);
    tick(3);
    rst = 1'b0;
    tick(2);
    src[0] = 1'b0;
    wait_idle(200);

    // single event on source 1
    pulse_src(1);
    wait_idle(200);

    // all three together, then 2 and 0 together
    src = 3'b111; tick(1); src = 3'b000;
    wait_idle(300);
    src = 3'b101; tick(1); src = 3'b000;
    wait_idle(300);

    // saturation of source 2 while source 0 is in flight
    pulse_src(0);
    repeat (5) pulse_src(2);
    wait_idle(400);
    chk("sat_ovf", ovf, 3'b100);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // config isolation: delay changed while the first event is delaying
    cfg_delay = 8'd5;
    pulse_src(1);
    tick(2);
    cfg_delay = 8'd20;
    pulse_src(1);
    wait_idle(300);

    // minimum timing: D=W=H=0
    cfg_delay = 8'd0; cfg_width = 8'd0; cfg_holdoff = 8'd0;
    pulse_src(0);
    pulse_src(0);
    wait_idle(100);

    // asynchronous reset in the middle of a pulse
    cfg_delay = 8'd2; cfg_width = 8'd6; cfg_holdoff = 8'd1;
    pulse_src(1);
    pulse_src(1);
    k = 0;
    while (!intr_out && k < 50) begin tick(1); k++; end
    chk("reached_assert", intr_out, 1);
    tick(1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_intr_out", intr_out, 0);
    chk("async_busy", busy, 0);
    tick(2);
    rst = 1'b0;
    rises_before = n_rise;
    tick(40);
    chk("no_pulse_after_reset", n_rise, rises_before);

    // randomized traffic
    cfg_delay = 8'd3; cfg_width = 8'd2; cfg_holdoff = 8'd1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) src[i] = ~src[i];
      end
      if (c % 50 == 0) begin
        cfg_delay   = 8'($urandom_range(0, 6));
        cfg_width   = 8'($urandom_range(0, 4));
        cfg_holdoff = 8'($urandom_range(0, 3));
      end
      clr_ovf = ($urandom_range(0, 40) == 0);
      tick(1);
    end
    src = '0;
    clr_ovf = 1'b0;
    wait_idle(3000);
    chk("queue_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
